// File: rtl/xor_serializer.sv
// Byte-stream serializer for the xor_encrypt output word. Buffers whole words in a
// small FIFO (no upstream backpressure exists) and emits them LSB-first over valid/ready.
module xor_serializer #(
  parameter int DATA_W = 256,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [DATA_W-1:0]            code_in,
  output logic [OUT_W-1:0]             byte_out,
  output logic                         byte_valid,
  input  logic                         byte_ready,
  output logic                         last,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         busy
);

  localparam int N     = DATA_W / OUT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic xfer, last_beat, fifo_ne, pop, push;

  always_comb begin
    xfer      = (state_q == SEND) && byte_ready;
    last_beat = (cnt_q == CNT_LAST);
    fifo_ne   = (level_q != '0);
    // Only a word already in the FIFO before this edge may be popped: no write bypass.
    pop       = fifo_ne && ((state_q == IDLE) || (xfer && last_beat));
    // A pop at the same edge frees a slot, so a full FIFO can still accept.
    push      = valid_in && ((level_q < LVL_FULL) || pop);

    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = code_in;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (valid_in && !push) begin
      ovf_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          sh_d    = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (pop) begin
            sh_d  = mem_q[rd_ptr_q];
            cnt_d = '0;
          end else begin
            sh_d  = sh_q >> OUT_W;
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
            if (last_beat) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Word storage carries no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign byte_out   = sh_q[OUT_W-1:0];
  assign byte_valid = (state_q == SEND);
  assign last       = (state_q == SEND) && (cnt_q == CNT_LAST);
  assign overflow   = ovf_q;
  assign fifo_level = level_q;
  assign busy       = (state_q == SEND) || (level_q != '0);

endmodule

// File: tb/tb_xor_serializer.sv
// Directed bench for xor_serializer: single word, backpressure, back-to-back,
// overflow, full-plus-pop and mid-word reset.
module tb_xor_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic [255:0] code_in;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         last;
  logic         overflow;
  logic [1:0]   fifo_level;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  int beat_no  = 0;
  logic [7:0] exp_q[$];

  xor_serializer #(.DATA_W(256), .OUT_W(8), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .code_in    (code_in),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .last       (last),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [255:0] make_word(input logic [7:0] base);
    logic [255:0] w;
    for (int i = 0; i < 32; i++) w[i*8 +: 8] = 8'(base + i);
    return w;
  endfunction

  task automatic expect_word(input logic [7:0] base);
    for (int i = 0; i < 32; i++) exp_q.push_back(8'(base + i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    beat_no = 0;
  endtask

  task automatic send_word(input logic [7:0] base);
    valid_in = 1'b1;
    code_in  = make_word(base);
    tick();
    valid_in = 1'b0;
    code_in  = '0;
  endtask

  // Runs the sink for n beats; alt toggles ready every cycle starting high.
  task automatic drain(input int n, input bit alt, input int exp_cyc);
    int got = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [7:0] pb = '0;
    logic pl = 1'b0;
    while (got < n && cyc < exp_cyc + 8) begin
      byte_ready = alt ? (cyc % 2 == 0) : 1'b1;
      if (held) begin
        chk("hold_data", byte_out, pb);
        chk("hold_last", last, pl);
      end
      held = byte_valid && !byte_ready;
      pb   = byte_out;
      pl   = last;
      if (byte_valid && byte_ready) begin
        chk("beat", byte_out, exp_q.pop_front());
        chk("last", last, (beat_no % 32) == 31);
        beat_no++;
        got++;
      end
      tick();
      cyc++;
    end
    chk("beat_count", got, n);
    chk("cycle_count", cyc, exp_cyc);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; code_in = '0; byte_ready = 1'b0;
    tick();
    do_reset();
    chk("rst_valid", byte_valid, 0);
    chk("rst_last", last, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_byte", byte_out, 0);
    chk("rst_level", fifo_level, 0);

    // Single word, ready held high
    byte_ready = 1'b1;
    send_word(8'h00);
    chk("t1_level", fifo_level, 1);
    chk("t1_valid_pre", byte_valid, 0);
    tick();
    expect_word(8'h00);
    drain(32, 1'b0, 32);
    chk("t1_valid_end", byte_valid, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_ovf_end", overflow, 0);

    // Backpressure: ready alternates
    byte_ready = 1'b0;
    send_word(8'h00);
    tick();
    expect_word(8'h00);
    drain(32, 1'b1, 63);
    byte_ready = 1'b0;
    tick();
    chk("t2_valid_end", byte_valid, 0);

    // Back-to-back words with ready low, then a contiguous drain
    send_word(8'h00);
    send_word(8'h40);
    send_word(8'h80);
    chk("t3_level", fifo_level, 2);
    chk("t3_ovf", overflow, 0);
    chk("t3_busy", busy, 1);
    chk("t3_valid", byte_valid, 1);
    expect_word(8'h00); expect_word(8'h40); expect_word(8'h80);
    drain(96, 1'b0, 96);
    chk("t3_valid_end", byte_valid, 0);

    // Overflow: fourth word dropped
    byte_ready = 1'b0;
    send_word(8'h10);
    send_word(8'h50);
    send_word(8'h90);
    send_word(8'hC0);
    chk("t4_ovf", overflow, 1);
    chk("t4_level", fifo_level, 2);
    expect_word(8'h10); expect_word(8'h50); expect_word(8'h90);
    drain(96, 1'b0, 96);
    chk("t4_no_w3", byte_valid, 0);
    chk("t4_ovf_sticky", overflow, 1);
    send_word(8'hA0);
    tick();
    chk("t4_ovf_traffic", overflow, 1);
    expect_word(8'hA0);
    drain(32, 1'b0, 32);

    // Full FIFO plus pop on the beat-31 transfer edge
    do_reset();
    chk("t5_rst_ovf", overflow, 0);
    byte_ready = 1'b0;
    send_word(8'h00);
    send_word(8'h40);
    send_word(8'h80);
    chk("t5_level_full", fifo_level, 2);
    expect_word(8'h00); expect_word(8'h40); expect_word(8'h80);
    drain(31, 1'b0, 31);
    chk("t5_last31", last, 1);
    chk("t5_beat31", byte_out, exp_q.pop_front());
    beat_no++;
    expect_word(8'hE0);
    send_word(8'hE0);
    chk("t5_ovf", overflow, 0);
    chk("t5_level", fifo_level, 2);
    chk("t5_valid", byte_valid, 1);
    drain(96, 1'b0, 96);
    chk("t5_valid_end", byte_valid, 0);

    // Reset during beat 10, with valid_in high on the reset edge
    do_reset();
    byte_ready = 1'b0;
    send_word(8'h00);
    send_word(8'h20);
    send_word(8'h40);
    send_word(8'h60);
    chk("t6_ovf_pre", overflow, 1);
    expect_word(8'h00);
    drain(10, 1'b0, 10);
    chk("t6_beat10", byte_out, 8'h0A);
    rst_n    = 1'b0;
    valid_in = 1'b1;
    code_in  = make_word(8'h33);
    tick();
    rst_n    = 1'b1;
    valid_in = 1'b0;
    chk("t6_valid", byte_valid, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_busy", busy, 0);
    chk("t6_byte", byte_out, 0);
    chk("t6_last", last, 0);
    exp_q.delete();
    beat_no = 0;
    send_word(8'h60);
    tick();
    expect_word(8'h60);
    drain(32, 1'b0, 32);
    chk("t6_valid_end", byte_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
